// File: rtl/player_hit_ctrl.sv
// player_hit_ctrl: detects player/moon sprite overlap during the visible scan
// and, once per frame, turns any overlap into a lost life. Manages a timed
// invulnerability window with blinking and a sticky game-over state.
module player_hit_ctrl #(
   parameter int LIVES_INIT    = 3,
   parameter int INVULN_FRAMES = 120,
   parameter int H_ACTIVE      = 640,
   parameter int V_ACTIVE      = 480,
   parameter int BLINK_BIT     = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic       frame_tick,
   input  logic       player_on,
   input  logic       moon_on,
   input  logic       restart,
   output logic [2:0] lives,
   output logic       hit_pulse,
   output logic       invuln,
   output logic       player_visible,
   output logic       game_over
);

   localparam logic [9:0] H_LIM     = 10'(H_ACTIVE);
   localparam logic [9:0] V_LIM     = 10'(V_ACTIVE);
   localparam logic [2:0] LIVES_RST = 3'(LIVES_INIT);
   localparam logic [7:0] INV_LOAD  = 8'(INVULN_FRAMES);

   typedef enum logic [1:0] {
      ALIVE     = 2'd0,
      INVULN    = 2'd1,
      GAME_OVER = 2'd2
   } state_t;

   state_t     state, state_next;
   logic [2:0] lives_next;
   logic [7:0] inv_cnt, inv_next;
   logic       overlap_seen, seen_next;
   logic       pulse_next;
   logic       visible_next;
   logic       ov, hit;

   // Overlap is only meaningful inside the visible area; the tick cycle itself counts.
   always_comb begin
      ov  = player_on & moon_on & (x < H_LIM) & (y < V_LIM);
      hit = overlap_seen | ov;
   end

   // Next-state logic: restart has priority, otherwise act only on frame_tick.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_next = state;
      lives_next = lives;
      inv_next   = inv_cnt;
      pulse_next = 1'b0;
      seen_next  = overlap_seen | ov;

      if (restart) begin
         state_next = ALIVE;
         lives_next = LIVES_RST;
         inv_next   = 8'd0;
         seen_next  = 1'b0;
      end else if (frame_tick) begin
         seen_next = 1'b0;
         unique case (state)
            ALIVE: begin
               if (hit) begin
                  pulse_next = 1'b1;
                  if (lives <= 3'd1) begin
                     lives_next = 3'd0;
                     state_next = GAME_OVER;
                  end else begin
                     lives_next = lives - 3'd1;
                     state_next = INVULN;
                     inv_next   = INV_LOAD;
                  end
               end
            end
            INVULN: begin
               if (inv_cnt <= 8'd1) begin
                  state_next = ALIVE;
                  inv_next   = 8'd0;
               end else begin
                  inv_next = inv_cnt - 8'd1;
               end
            end
            GAME_OVER: begin
               lives_next = 3'd0;
            end
            default: begin
               state_next = ALIVE;
            end
         endcase
      end
   end

   // Sprite gate derived from the state being entered, so it lines up with invuln/game_over.
   always_comb begin
      visible_next = 1'b1;
      unique case (state_next)
         ALIVE:     visible_next = 1'b1;
         INVULN:    visible_next = inv_next[BLINK_BIT];
         GAME_OVER: visible_next = 1'b0;
         default:   visible_next = 1'b1;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: every flop here is a control register and takes the async reset; state updates use <= only.
      if (!reset) begin
         state          <= ALIVE;
         lives          <= LIVES_RST;
         inv_cnt        <= 8'd0;
         overlap_seen   <= 1'b0;
         hit_pulse      <= 1'b0;
         invuln         <= 1'b0;
         game_over      <= 1'b0;
         player_visible <= 1'b1;
      end else begin
         state          <= state_next;
         lives          <= lives_next;
         inv_cnt        <= inv_next;
         overlap_seen   <= seen_next;
         hit_pulse      <= pulse_next;
         invuln         <= (state_next == INVULN);
         game_over      <= (state_next == GAME_OVER);
         player_visible <= visible_next;
      end
   end

endmodule

// File: tb/tb_player_hit_ctrl.sv
// Testbench for player_hit_ctrl: directed frames compared every cycle against
// a frame-level model (lives count, frames of protection left), plus literal
// expectations at the notable points of each scenario.
module tb_player_hit_ctrl;

   localparam int LIVES = 3;
   localparam int INV   = 120;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [9:0] x = '0, y = '0;
   logic       frame_tick = 1'b0, player_on = 1'b0, moon_on = 1'b0, restart = 1'b0;
   logic [2:0] lives;
   logic       hit_pulse, invuln, player_visible, game_over;

   int tests = 0;
   int failed = 0;
   bit cmp_en = 1'b0;

   player_hit_ctrl dut (
      .clk(clk), .reset(reset), .x(x), .y(y), .frame_tick(frame_tick),
      .player_on(player_on), .moon_on(moon_on), .restart(restart),
      .lives(lives), .hit_pulse(hit_pulse), .invuln(invuln),
      .player_visible(player_visible), .game_over(game_over)
   );

   always #5 clk = ~clk;

   // Frame-level model: lives left, frames of protection remaining, overlap seen this frame.
   typedef struct {
      int lives;
      int prot_left;
      bit seen;
      bit pulse;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r.lives = LIVES; r.prot_left = 0; r.seen = 0; r.pulse = 0;
      return r;
   endfunction

   function automatic model_t model_step(model_t cur, int px, int py, bit p, bit mo, bit tk, bit rs);
      model_t n = cur;
      bit touching = p && mo && px < 640 && py < 480;
      n.pulse = 0;
      if (rs) begin
         n = model_reset();
      end else if (tk) begin
         n.seen = 0;
         if (cur.prot_left > 0) begin
            n.prot_left = cur.prot_left - 1;
         end else if (cur.lives > 0 && (cur.seen || touching)) begin
            n.lives = cur.lives - 1;
            n.pulse = 1;
            n.prot_left = (n.lives > 0) ? INV : 0;
         end
      end else begin
         n.seen = cur.seen || touching;
      end
      return n;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) m <= model_reset();
      else        m <= model_step(m, x, y, player_on, moon_on, frame_tick, restart);
   end

   function automatic bit exp_visible(model_t s);
      if (s.lives == 0)    return 1'b0;
      if (s.prot_left > 0) return s.prot_left[2];
      return 1'b1;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("cyc_lives",   int'(lives),          m.lives);
         check("cyc_pulse",   int'(hit_pulse),      int'(m.pulse));
         check("cyc_invuln",  int'(invuln),         int'(m.prot_left > 0));
         check("cyc_gameovr", int'(game_over),      int'(m.lives == 0));
         check("cyc_visible", int'(player_visible), int'(exp_visible(m)));
      end
   end

   // Apply one cycle of inputs (called at a negedge, returns at the next negedge).
   task automatic cyc(input int px, input int py, input bit p, input bit mo, input bit tk, input bit rs);
      x = 10'(px); y = 10'(py);
      player_on = p; moon_on = mo; frame_tick = tk; restart = rs;
      @(negedge clk);
      player_on = 0; moon_on = 0; frame_tick = 0; restart = 0;
   endtask

   // One frame: optional overlap at (300,400), then the tick, then an idle cycle.
   task automatic frame(input bit overlap);
      cyc(300, 400, overlap, overlap, 0, 0);
      cyc(700, 500, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0);
   endtask

   task automatic check_outputs(input string tag, input int l, input bit hp, input bit iv,
                                input bit vis, input bit go);
      check({tag, "_lives"},   int'(lives),          l);
      check({tag, "_pulse"},   int'(hit_pulse),      int'(hp));
      check({tag, "_invuln"},  int'(invuln),         int'(iv));
      check({tag, "_visible"}, int'(player_visible), int'(vis));
      check({tag, "_gameovr"}, int'(game_over),      int'(go));
   endtask

   initial begin
      // 1: reset release, idle
      repeat (2) @(negedge clk);
      reset = 1'b1;
      cmp_en = 1'b1;
      repeat (3) cyc(0, 0, 0, 0, 0, 0);
      check_outputs("t1", 3, 0, 0, 1, 0);

      // 2: single-cycle overlap, then tick -> pulse for exactly one cycle
      cyc(300, 400, 1, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(700, 500, 0, 0, 1, 0);
      check_outputs("t2_hit", 2, 1, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      check("t2_pulse_once", int'(hit_pulse), 0);

      // 3: overlap every frame while protected; blink pattern, exit on 120th tick
      for (int k = 1; k <= 119; k++) begin
         frame(1'b1);
         if (k == 1)   check("t3_vis_k1",   int'(player_visible), 1);
         if (k == 4)   check("t3_vis_k4",   int'(player_visible), 1);
         if (k == 5)   check("t3_vis_k5",   int'(player_visible), 0);
         if (k == 9)   check("t3_vis_k9",   int'(player_visible), 1);
      end
      check_outputs("t3_k119", 2, 0, 1, 0, 0);
      frame(1'b1);
      check_outputs("t3_k120", 2, 0, 0, 1, 0);

      // 4: overlap only in blanking -> no hit; x=639,y=479 is still visible
      cyc(0, 0, 0, 0, 0, 1);
      check("t4_restart_lives", int'(lives), 3);
      cyc(700, 100, 1, 1, 0, 0);
      cyc(100, 480, 1, 1, 0, 0);
      cyc(640, 479, 1, 1, 1, 0);
      check_outputs("t4", 3, 0, 0, 1, 0);
      cyc(639, 479, 1, 1, 1, 0);
      check_outputs("t4_edge", 2, 1, 1, 0, 0);

      // 5: run lives down to zero (one hit taken via overlap on the tick cycle itself)
      cyc(0, 0, 0, 0, 0, 1);
      frame(1'b1);
      check("t5_hit1", int'(lives), 2);
      repeat (INV) frame(1'b0);
      check("t5_alive1", int'(invuln), 0);
      cyc(10, 10, 1, 1, 1, 0);
      check("t5_hit2", int'(lives), 1);
      check("t5_pulse2", int'(hit_pulse), 1);
      repeat (INV) frame(1'b0);
      frame(1'b1);
      check_outputs("t5_dead", 0, 0, 0, 0, 1);
      repeat (3) frame(1'b1);
      check_outputs("t5_dead_hold", 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      check_outputs("t5_restart", 3, 0, 0, 1, 0);

      // 6a: overlap, then restart together with a tick -> restart wins
      cyc(300, 400, 1, 1, 0, 0);
      cyc(300, 400, 1, 1, 1, 1);
      check_outputs("t6_rst_tick", 3, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);
      check("t6_seen_cleared", int'(hit_pulse), 0);

      // 6b: async reset mid-protection returns outputs immediately
      frame(1'b1);
      repeat (5) frame(1'b0);
      check("t6_in_invuln", int'(invuln), 1);
      #2 reset = 1'b0;
      #1;
      check_outputs("t6_async", 3, 0, 0, 1, 0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) cyc(0, 0, 0, 0, 0, 0);
      check_outputs("t6_after", 3, 0, 0, 1, 0);

      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
